regbank_write_demux: RTL and testbench
======================================

REGBANK_WRITE_DEMUX -- requirements
Module: regbank_write_demux

Interface
REQ-001 SHALL have parameter N, default 64: width of each register in bits; N SHALL be a multiple of 8.
REQ-002 SHALL have parameter ZERO_REG, default 1: when 1, register 31 is hardwired to zero.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1: write request, sampled each rising edge.
REQ-006 SHALL have port wr_addr  input  5: destination register index 0..31.
REQ-007 SHALL have port wr_data  input  N: write data.
REQ-008 SHALL have port wr_be  input  N/8: byte enables; bit i covers wr_data[8i+7:8i].
REQ-009 SHALL have port busy  output  1: high while the sequential clear is in progress.
REQ-010 SHALL have port wr_ack  output  1: one-cycle pulse for each accepted write.
REQ-011 SHALL have port wr_rej  output  1: one-cycle pulse for each write dropped while busy.
REQ-012 SHALL have port q_flat  output  32*N: all register contents; register k occupies bits [k*N+N-1 : k*N], feeding the 32:1 read selectors.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and READY.
REQ-014 CLEAR SHALL zero one register per cycle using a 5-bit counter clr_idx, from 0 upward.
REQ-015 CLEAR SHALL transition to READY on the edge that clears index 30; the clear takes 31 cycles.
REQ-016 busy SHALL be 1 in CLEAR and 0 in READY, decoded directly from state.
REQ-017 In READY, a write SHALL be accepted when wr_en=1.
REQ-018 An accepted write SHALL update register wr_addr on the same rising edge it is sampled.
REQ-019 The update SHALL affect only bytes whose wr_be bit is 1; all other bytes SHALL hold their value.
REQ-020 wr_be all-zero SHALL still count as accepted: wr_ack pulses and the register is unchanged.
REQ-021 With ZERO_REG=1, writes to index 31 SHALL be accepted and acked, and the data SHALL be discarded.
REQ-022 With ZERO_REG=1, q_flat slice 31 SHALL always read 0.
REQ-023 With ZERO_REG=0, index 31 SHALL be an ordinary register, and CLEAR SHALL cover indices 0..31 in 32 cycles.
REQ-024 wr_ack SHALL be registered: high for exactly the one cycle after the accepting edge.
REQ-025 When wr_en=1 in CLEAR, the write SHALL be dropped with no register change, and wr_rej SHALL pulse the cycle after.
REQ-026 On the final CLEAR edge, a simultaneous wr_en SHALL be rejected; acceptance begins on the first edge with state=READY.
REQ-027 q_flat SHALL be driven directly from register outputs, with no combinational path from any wr_* input.
REQ-028 Back-to-back writes, one per cycle, SHALL be supported at full rate, including repeated writes to the same address (the last one wins).
REQ-029 wr_ack and wr_rej SHALL never both be high in the same cycle.

Reset
REQ-030 reset=1 at an edge SHALL force: state=CLEAR, clr_idx=0, wr_ack=0, wr_rej=0.
REQ-031 While reset=1, busy SHALL be 1.
REQ-032 Register contents SHALL NOT be cleared by reset directly; each is zeroed by the sequential clear.
REQ-033 reset asserted mid-CLEAR or in READY SHALL restart the clear from index 0.
REQ-034 reset SHALL have priority over wr_en on the same edge; the write is dropped and wr_rej is not pulsed.

Verification
REQ-035 Bench: reset 1 cycle, then idle -> busy=1 for 31 cycles then 0, q_flat=0 in all slices, no wr_ack or wr_rej pulses.
REQ-036 Bench: in READY, write addr 5, data 0x0123456789ABCDEF, be=0xFF; then write addr 5, data 0xFFFF..FF, be=0x01 -> slice 5=0x0123456789ABCDFF, wr_ack pulses twice, other slices stay 0.
REQ-037 Bench: write addr 31, data 0xDEAD, be=0xFF -> wr_ack=1 one cycle later, slice 31 remains 0.
REQ-038 Bench: wr_en=1 held from reset release to READY, addr 3, data 0xAA -> wr_rej high for 31 cycles, then wr_ack, slice 3=0xAA.
REQ-039 Bench: reset pulsed at clear cycle 10 after writes left slices 0..30 nonzero -> busy extends to 31 cycles after the second reset, all slices end at 0.
REQ-040 Bench: 32 consecutive writes, addr k, data k, be=0xFF -> 32 consecutive wr_ack cycles, slice k=k for k<31, slice 31=0.

Source files
------------

// File: rtl/regbank_write_demux.sv
// regbank_write_demux
//   32 x N register bank with byte-enabled writes and a sequential clear.
//   After reset, the bank zeroes one register per cycle (CLEAR) before
//   writes are accepted (READY). With ZERO_REG=1, register 31 reads as zero.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset; restarts the clear
//   wr_en    in   write request
//   wr_addr  in   [4:0] destination register
//   wr_data  in   [N-1:0] write data
//   wr_be    in   [N/8-1:0] byte enables, bit i -> wr_data[8i+7:8i]
//   busy     out  high while the clear is running
//   wr_ack   out  one-cycle pulse after each accepted write
//   wr_rej   out  one-cycle pulse after each write dropped during the clear
//   q_flat   out  [32*N-1:0] register k at bits [k*N +: N]
module regbank_write_demux #(
  parameter int unsigned N        = 64,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic [N/8-1:0]    wr_be,
  output logic              busy,
  output logic              wr_ack,
  output logic              wr_rej,
  output logic [32*N-1:0]   q_flat
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // With a hardwired register 31 the clear stops one index early.
  localparam logic [4:0] LAST_IDX = ZERO_REG ? 5'd30 : 5'd31;

  state_e         state_q, state_d;
  logic [4:0]     clr_idx_q, clr_idx_d;
  logic           ack_q, ack_d;
  logic           rej_q, rej_d;

  logic [N-1:0]   regs_q [32];

  // Single write port shared by the clear and by external writes.
  logic           we;
  logic [4:0]     we_idx;
  logic [N-1:0]   we_data;
  logic [N-1:0]   we_mask;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ack_d     = 1'b0;
    rej_d     = 1'b0;
    we        = 1'b0;
    we_idx    = wr_addr;
    we_data   = wr_data;
    we_mask   = '0;

    unique case (state_q)
      ST_CLEAR: begin
        we        = 1'b1;
        we_idx    = clr_idx_q;
        we_data   = '0;
        we_mask   = '1;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_READY;
        end
        rej_d = wr_en;
      end
      ST_READY: begin
        if (wr_en) begin
          ack_d = 1'b1;
          // Writes to the hardwired zero register are acked but discarded.
          we    = !(ZERO_REG && (wr_addr == 5'd31));
          for (int unsigned b = 0; b < N/8; b++) begin
            we_mask[8*b +: 8] = {8{wr_be[b]}};
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    // Reset overrides everything on the same edge, including writes.
    if (reset) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
      ack_d     = 1'b0;
      rej_d     = 1'b0;
      we        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    ack_q     <= ack_d;
    rej_q     <= rej_d;
  end

  // Storage has no reset; zeroing is done by the sequential clear.
  always_ff @(posedge clk) begin
    if (we) begin
      regs_q[we_idx] <= (regs_q[we_idx] & ~we_mask) | (we_data & we_mask);
    end
  end

  assign busy   = (state_q == ST_CLEAR);
  assign wr_ack = ack_q;
  assign wr_rej = rej_q;

  for (genvar k = 0; k < 32; k++) begin : g_q
    if (ZERO_REG && (k == 31)) begin : g_zero
      assign q_flat[k*N +: N] = '0;
    end else begin : g_reg
      assign q_flat[k*N +: N] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_regbank_write_demux.sv
module tb_regbank_write_demux;

  localparam int unsigned N = 64;

  logic            clk;
  logic            reset;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic [N/8-1:0]  wr_be;
  logic            busy;
  logic            wr_ack;
  logic            wr_rej;
  logic [32*N-1:0] q_flat;

  int tests;
  int fails;

  regbank_write_demux #(.N(N), .ZERO_REG(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .busy    (busy),
    .wr_ack  (wr_ack),
    .wr_rej  (wr_rej),
    .q_flat  (q_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] slice(input int unsigned k);
    return q_flat[k*N +: N];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Counts cycles with busy high, bounded.
  task automatic count_busy(output int n, output bit pulse_seen);
    n = 0;
    pulse_seen = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      if (wr_ack !== 1'b0 || wr_rej !== 1'b0) pulse_seen = 1'b1;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    bit pulse;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    @(negedge clk);
    step();
    tests++;
    if (busy !== 1'b1 || wr_ack !== 1'b0 || wr_rej !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: busy=%b ack=%b rej=%b, required 1 0 0", busy, wr_ack, wr_rej);
    end
    reset = 1'b0;
    count_busy(n, pulse);
    tests++;
    if (n !== 31) begin
      fails++;
      $display("FAIL reset_busy_len: got %0d cycles, required 31", n);
    end
    tests++;
    if (pulse !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_pulses: saw ack/rej pulse during idle clear");
    end
    for (int unsigned k = 0; k < 32; k++) begin
      tests++;
      if (slice(k) !== '0) begin
        fails++;
        $display("FAIL reset_slice%0d: got %h, required 0", k, slice(k));
      end
    end
  endtask

  task automatic test_byte_write();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h0123456789ABCDEF; wr_be = 8'hFF;
    step();
    tests++;
    if (wr_ack !== 1'b1 || wr_rej !== 1'b0) begin
      fails++;
      $display("FAIL bw_ack1: ack=%b rej=%b, required 1 0", wr_ack, wr_rej);
    end
    wr_data = '1; wr_be = 8'h01;
    step();
    tests++;
    if (wr_ack !== 1'b1) begin
      fails++;
      $display("FAIL bw_ack2: ack=%b, required 1", wr_ack);
    end
    wr_en = 1'b0;
    step();
    tests++;
    if (wr_ack !== 1'b0) begin
      fails++;
      $display("FAIL bw_ack_end: ack=%b, required 0", wr_ack);
    end
    tests++;
    if (slice(5) !== 64'h0123456789ABCDFF) begin
      fails++;
      $display("FAIL bw_slice5: got %h, required 0123456789abcdff", slice(5));
    end
    for (int unsigned k = 0; k < 32; k++) begin
      if (k != 5) begin
        tests++;
        if (slice(k) !== '0) begin
          fails++;
          $display("FAIL bw_other%0d: got %h, required 0", k, slice(k));
        end
      end
    end
    // All-zero byte enables: acked, register untouched.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = '0; wr_be = 8'h00;
    step();
    tests++;
    if (wr_ack !== 1'b1) begin
      fails++;
      $display("FAIL be0_ack: ack=%b, required 1", wr_ack);
    end
    wr_en = 1'b0;
    step();
    tests++;
    if (slice(5) !== 64'h0123456789ABCDFF) begin
      fails++;
      $display("FAIL be0_slice5: got %h, required 0123456789abcdff", slice(5));
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hDEAD; wr_be = 8'hFF;
    step();
    tests++;
    if (wr_ack !== 1'b1) begin
      fails++;
      $display("FAIL zr_ack: ack=%b, required 1", wr_ack);
    end
    wr_en = 1'b0;
    step();
    tests++;
    if (slice(31) !== '0 || wr_ack !== 1'b0) begin
      fails++;
      $display("FAIL zr_slice31: got %h ack=%b, required 0 0", slice(31), wr_ack);
    end
  endtask

  task automatic test_rej_during_clear();
    int n;
    bit both;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hAA; wr_be = 8'hFF;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (wr_rej !== 1'b0 || wr_ack !== 1'b0) begin
      fails++;
      $display("FAIL rej_on_reset: rej=%b ack=%b, required 0 0", wr_rej, wr_ack);
    end
    n = 0;
    both = 1'b0;
    step();
    while (wr_rej === 1'b1 && n < 100) begin
      if (wr_ack !== 1'b0) both = 1'b1;
      n++;
      step();
    end
    tests++;
    if (n !== 31) begin
      fails++;
      $display("FAIL rej_len: got %0d cycles, required 31", n);
    end
    tests++;
    if (both !== 1'b0) begin
      fails++;
      $display("FAIL rej_ack_overlap: ack and rej high together");
    end
    tests++;
    if (wr_ack !== 1'b1 || wr_rej !== 1'b0) begin
      fails++;
      $display("FAIL rej_then_ack: ack=%b rej=%b, required 1 0", wr_ack, wr_rej);
    end
    wr_en = 1'b0;
    step();
    tests++;
    if (slice(3) !== 64'hAA) begin
      fails++;
      $display("FAIL rej_slice3: got %h, required aa", slice(3));
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit pulse;
    for (int unsigned k = 0; k < 31; k++) begin
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = 64'(k + 1); wr_be = 8'hFF;
      step();
    end
    wr_en = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    tests++;
    if (slice(5) !== '0 || slice(20) !== 64'd21) begin
      fails++;
      $display("FAIL mid_partial: slice5=%h slice20=%h, required 0 15", slice(5), slice(20));
    end
    do_reset();
    count_busy(n, pulse);
    tests++;
    if (n !== 31) begin
      fails++;
      $display("FAIL mid_busy_len: got %0d cycles, required 31", n);
    end
    for (int unsigned k = 0; k < 32; k++) begin
      tests++;
      if (slice(k) !== '0) begin
        fails++;
        $display("FAIL mid_slice%0d: got %h, required 0", k, slice(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = 64'(k); wr_be = 8'hFF;
      step();
      if (wr_ack === 1'b1 && wr_rej === 1'b0) acks++;
    end
    wr_en = 1'b0;
    step();
    tests++;
    if (acks !== 32 || wr_ack !== 1'b0) begin
      fails++;
      $display("FAIL b2b_acks: got %0d acks (trailing ack=%b), required 32 (0)", acks, wr_ack);
    end
    for (int unsigned k = 0; k < 32; k++) begin
      tests++;
      if (slice(k) !== ((k < 31) ? 64'(k) : 64'd0)) begin
        fails++;
        $display("FAIL b2b_slice%0d: got %h, required %h", k, slice(k), (k < 31) ? 64'(k) : 64'd0);
      end
    end
    // Same address twice in a row: last write wins.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1111; wr_be = 8'hFF;
    step();
    wr_data = 64'h2222;
    step();
    wr_en = 1'b0;
    step();
    tests++;
    if (slice(7) !== 64'h2222) begin
      fails++;
      $display("FAIL b2b_last_wins: got %h, required 2222", slice(7));
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h55; wr_be = 8'hFF;
    step();
    tests++;
    if (wr_ack !== 1'b0 || wr_rej !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_prio: ack=%b rej=%b busy=%b, required 0 0 1", wr_ack, wr_rej, busy);
    end
    reset = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 31; i++) step();
    tests++;
    if (busy !== 1'b0 || slice(4) !== '0) begin
      fails++;
      $display("FAIL rst_prio_end: busy=%b slice4=%h, required 0 0", busy, slice(4));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_byte_write();
    test_zero_reg();
    test_rej_during_clear();
    test_reset_mid_clear();
    test_back_to_back();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
